// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, MIPS opcode/funct constants and issue record types
package alu_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_ADDU    = 4'b1000;
    localparam logic [3:0] ALU_SUBU    = 4'b1001;
    localparam logic [3:0] ALU_XOR     = 4'b1010;
    localparam logic [3:0] ALU_SLTU    = 4'b1011;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_SRA     = 4'b1101;
    localparam logic [3:0] ALU_LUI     = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand-routing class chosen by the opcode/funct decode.
    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RR,
        SEL_SHAMT,
        SEL_SHV,
        SEL_IMM_S,
        SEL_IMM_Z,
        SEL_LUI,
        SEL_STORE,
        SEL_BRANCH
    } operand_sel_e;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [4:0]  dest_reg;
        logic        reg_write;
        logic        illegal_op;
    } issue_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational MIPS decode into ALU opcode, operands and writeback target
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [3:0]  ALUCtrl,
    output logic [31:0] BusA,
    output logic [31:0] BusB,
    output logic [4:0]  DestReg,
    output logic        RegWrite,
    output logic        IllegalOp
);

    logic [5:0]   w_op;
    logic [5:0]   w_fn;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [4:0]   w_shamt;
    logic [15:0]  w_imm;
    logic         w_unused_rs;
    operand_sel_e w_sel;

    assign w_op        = Instr[31:26];
    assign w_rt        = Instr[20:16];
    assign w_rd        = Instr[15:11];
    assign w_shamt     = Instr[10:6];
    assign w_fn        = Instr[5:0];
    assign w_imm       = Instr[15:0];
    assign w_unused_rs = ^Instr[25:21];

    always_comb begin
        ALUCtrl = ALU_ILLEGAL;
        w_sel   = SEL_NONE;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD:  begin ALUCtrl = ALU_ADD;  w_sel = SEL_RR;    end
                    FN_ADDU: begin ALUCtrl = ALU_ADDU; w_sel = SEL_RR;    end
                    FN_SUB:  begin ALUCtrl = ALU_SUB;  w_sel = SEL_RR;    end
                    FN_SUBU: begin ALUCtrl = ALU_SUBU; w_sel = SEL_RR;    end
                    FN_AND:  begin ALUCtrl = ALU_AND;  w_sel = SEL_RR;    end
                    FN_OR:   begin ALUCtrl = ALU_OR;   w_sel = SEL_RR;    end
                    FN_XOR:  begin ALUCtrl = ALU_XOR;  w_sel = SEL_RR;    end
                    FN_NOR:  begin ALUCtrl = ALU_NOR;  w_sel = SEL_RR;    end
                    FN_SLT:  begin ALUCtrl = ALU_SLT;  w_sel = SEL_RR;    end
                    FN_SLTU: begin ALUCtrl = ALU_SLTU; w_sel = SEL_RR;    end
                    FN_SLL:  begin ALUCtrl = ALU_SLL;  w_sel = SEL_SHAMT; end
                    FN_SRL:  begin ALUCtrl = ALU_SRL;  w_sel = SEL_SHAMT; end
                    FN_SRA:  begin ALUCtrl = ALU_SRA;  w_sel = SEL_SHAMT; end
                    FN_SLLV: begin ALUCtrl = ALU_SLL;  w_sel = SEL_SHV;   end
                    FN_SRLV: begin ALUCtrl = ALU_SRL;  w_sel = SEL_SHV;   end
                    FN_SRAV: begin ALUCtrl = ALU_SRA;  w_sel = SEL_SHV;   end
                    default: ;
                endcase
            end
            OP_ADDI:  begin ALUCtrl = ALU_ADD;  w_sel = SEL_IMM_S;  end
            OP_ADDIU: begin ALUCtrl = ALU_ADDU; w_sel = SEL_IMM_S;  end
            OP_SLTI:  begin ALUCtrl = ALU_SLT;  w_sel = SEL_IMM_S;  end
            OP_SLTIU: begin ALUCtrl = ALU_SLTU; w_sel = SEL_IMM_S;  end
            OP_ANDI:  begin ALUCtrl = ALU_AND;  w_sel = SEL_IMM_Z;  end
            OP_ORI:   begin ALUCtrl = ALU_OR;   w_sel = SEL_IMM_Z;  end
            OP_XORI:  begin ALUCtrl = ALU_XOR;  w_sel = SEL_IMM_Z;  end
            OP_LUI:   begin ALUCtrl = ALU_LUI;  w_sel = SEL_LUI;    end
            OP_LW:    begin ALUCtrl = ALU_ADD;  w_sel = SEL_IMM_S;  end
            OP_SW:    begin ALUCtrl = ALU_ADD;  w_sel = SEL_STORE;  end
            OP_BEQ,
            OP_BNE:   begin ALUCtrl = ALU_SUB;  w_sel = SEL_BRANCH; end
            default: ;
        endcase
    end

    // Shifts put the shifted value (rt) on BusA and the amount on BusB.
    always_comb begin
        BusA     = '0;
        BusB     = '0;
        DestReg  = '0;
        RegWrite = 1'b0;
        case (w_sel)
            SEL_RR:     begin BusA = RsData; BusB = RtData;               DestReg = w_rd; RegWrite = 1'b1; end
            SEL_SHAMT:  begin BusA = RtData; BusB = {27'b0, w_shamt};     DestReg = w_rd; RegWrite = 1'b1; end
            SEL_SHV:    begin BusA = RtData; BusB = {27'b0, RsData[4:0]}; DestReg = w_rd; RegWrite = 1'b1; end
            SEL_IMM_S:  begin BusA = RsData; BusB = sext16(w_imm);        DestReg = w_rt; RegWrite = 1'b1; end
            SEL_IMM_Z:  begin BusA = RsData; BusB = {16'b0, w_imm};       DestReg = w_rt; RegWrite = 1'b1; end
            SEL_LUI:    begin BusA = '0;     BusB = {16'b0, w_imm};       DestReg = w_rt; RegWrite = 1'b1; end
            SEL_STORE:  begin BusA = RsData; BusB = sext16(w_imm);        DestReg = w_rt; end
            SEL_BRANCH: begin BusA = RsData; BusB = RtData; end
            default: ;
        endcase
        if (DestReg == 5'd0) begin
            RegWrite = 1'b0;
        end
    end

    assign IllegalOp = (w_sel == SEL_NONE);

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - one-entry registered ALU issue stage with valid/ready handshake and issue counter
module alu_issue
    import alu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [31:0]      RsData,
    input  logic [31:0]      RtData,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      BusA,
    output logic [31:0]      BusB,
    output logic [3:0]       ALUCtrl,
    output logic [4:0]       DestReg,
    output logic             RegWrite,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] IssueCount
);

    issue_op_t        w_dec;
    issue_op_t        r_op;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_ready;

    alu_decode u_decode (
        .Instr     (Instr),
        .RsData    (RsData),
        .RtData    (RtData),
        .ALUCtrl   (w_dec.alu_ctrl),
        .BusA      (w_dec.bus_a),
        .BusB      (w_dec.bus_b),
        .DestReg   (w_dec.dest_reg),
        .RegWrite  (w_dec.reg_write),
        .IllegalOp (w_dec.illegal_op)
    );

    assign w_in_ready = !r_valid || OutReady;

    // Flush only drops the valid bit; the payload is don't-care once invalid.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_valid <= 1'b0;
            r_op    <= '0;
        end else if (Flush) begin
            r_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_valid <= InValid;
            if (InValid) begin
                r_op <= w_dec;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_cnt <= '0;
        end else if (r_valid && OutReady) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign InReady    = w_in_ready;
    assign OutValid   = r_valid;
    assign BusA       = r_op.bus_a;
    assign BusB       = r_op.bus_b;
    assign ALUCtrl    = r_op.alu_ctrl;
    assign DestReg    = r_op.dest_reg;
    assign RegWrite   = r_op.reg_write;
    assign IllegalOp  = r_op.illegal_op;
    assign IssueCount = r_cnt;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one parameter: CNT_W, default 16, width of the issue counter.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_L, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port InValid, input, 1 bit: Instr/RsData/RtData are valid this cycle.
REQ-005 SHALL have port InReady, output, 1 bit: the stage accepts the input this cycle.
REQ-006 SHALL have port Instr, input, 32 bits: MIPS instruction word.
REQ-007 SHALL have ports RsData and RtData, input, 32 bits each: register operands.
REQ-008 SHALL have port Flush, input, 1 bit: discard the held and incoming operation.
REQ-009 SHALL have port OutValid, output, 1 bit: the ALU operation below is valid.
REQ-010 SHALL have port OutReady, input, 1 bit: downstream (ALU/EX) accepts this cycle.
REQ-011 SHALL have ports BusA and BusB, output, 32 bits each: ALU operands.
REQ-012 SHALL have port ALUCtrl, output, 4 bits: ALU opcode.
REQ-013 SHALL have ports DestReg, output, 5 bits, and RegWrite, output, 1 bit: writeback target and enable.
REQ-014 SHALL have port IllegalOp, output, 1 bit: the held instruction is not decodable.
REQ-015 SHALL have port IssueCount, output, CNT_W bits: count of completed output handshakes.

Function
REQ-016 SHALL be a one-entry registered stage; InReady = !OutValid | OutReady; accept on InValid & InReady; latency 1 cycle.
REQ-017 While OutValid & !OutReady, every output SHALL hold stable.
REQ-018 Flush SHALL clear OutValid next cycle and drop the input even if InValid & InReady; Flush wins over all simultaneous events.
REQ-019 ALUCtrl codes SHALL be: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110, ILLEGAL 1111.
REQ-020 For opcode 0x00, funct 20/21/22/23/24/25/26/27/2A/2B SHALL map to ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU, with BusA=RsData, BusB=RtData, DestReg=rd, RegWrite=1.
REQ-021 Funct 00/02/03 (SLL/SRL/SRA) SHALL give BusA=RtData and BusB={27'b0,shamt}; funct 04/06/07 (SLLV/SRLV/SRAV) SHALL give BusA=RtData and BusB={27'b0,RsData[4:0]}; DestReg=rd.
REQ-022 Opcodes 08/09/0A/0B (ADDI/ADDIU/SLTI/SLTIU) SHALL map to ADD/ADDU/SLT/SLTU with BusB sign-extended imm16; 0C/0D/0E (ANDI/ORI/XORI) SHALL map to AND/OR/XOR with BusB zero-extended; BusA=RsData, DestReg=rt, RegWrite=1.
REQ-023 LUI (0x0F) SHALL give ALUCtrl=1110, BusA=0 and BusB={16'b0,imm16}, so the ALU yields {imm16,16'h0000}; DestReg=rt.
REQ-024 LW (0x23) SHALL map to ADD with sign-extended imm16 and DestReg=rt, RegWrite=1; SW (0x2B) the same with RegWrite=0.
REQ-025 BEQ/BNE (04/05) SHALL give SUB with BusA=RsData and BusB=RtData, RegWrite=0.
REQ-026 Any other opcode/funct SHALL give ALUCtrl=1111, IllegalOp=1, RegWrite=0 and BusA=BusB=0, and the operation is still issued.
REQ-027 A write with DestReg=0 SHALL force RegWrite=0.
REQ-028 IssueCount SHALL increment on OutValid & OutReady and wrap from 2^CNT_W-1 to 0.

Reset
REQ-029 Reset_L low SHALL asynchronously clear OutValid, IllegalOp, RegWrite, BusA, BusB, DestReg and IssueCount, and set ALUCtrl=0000; a held operation is lost.
REQ-030 InReady SHALL be 1 during reset and on the first cycle after reset.

Structure
REQ-031 The ALUCtrl codes, the opcode/funct constants and CNT_W's default SHALL live in a shared package, alu_pkg, which the ALU also uses.
REQ-032 The decode logic SHALL be a combinational sub-module, alu_decode (Instr, RsData, RtData in; ALUCtrl, BusA, BusB, DestReg, RegWrite, IllegalOp out), and alu_issue SHALL hold the register, handshake and counter.

Verification
REQ-033 ADDI $t1,$t0,-1 (0x2109FFFF), RsData=5 -> next cycle ALUCtrl=0010, BusA=5, BusB=FFFFFFFF, DestReg=9, RegWrite=1.
REQ-034 SRA $t2,$t1,4 with RtData=80000000 -> ALUCtrl=1101, BusA=80000000, BusB=4.
REQ-035 LUI $t0,0x1234 -> ALUCtrl=1110, BusA=0, BusB=00001234, DestReg=8.
REQ-036 Hold OutReady=0 for 3 cycles with InValid=1 -> InReady=0 and outputs frozen; on release, one handshake occurs and IssueCount increments by 1.
REQ-037 Flush in the same cycle as InValid & InReady -> OutValid=0 next cycle and IssueCount unchanged; Reset_L pulsed low mid-stall -> all outputs reset immediately.
REQ-038 Opcode 0x3F -> ALUCtrl=1111, IllegalOp=1, RegWrite=0; with CNT_W=4, 16 handshakes -> IssueCount wraps to 0.
